// File: rtl/serv_rf_ram_bridge.sv
// Bridge between the bit-serial register-file port of serv_top and a word-wide RF RAM.
// Reads fetch word 0 for both ports up front, then prefetch each next word while the
// current one shifts out. Writes gather bits into per-port accumulators and strobe each
// completed word, port 0 first and port 1 one cycle later.
module serv_rf_ram_bridge #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 6 + $clog2(32 / WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rreq,
  input  logic             i_wreq,
  output logic             o_ready,
  input  logic [5:0]       i_rreg0,
  input  logic [5:0]       i_rreg1,
  output logic             o_rdata0,
  output logic             o_rdata1,
  input  logic [5:0]       i_wreg0,
  input  logic [5:0]       i_wreg1,
  input  logic             i_wen0,
  input  logic             i_wen1,
  input  logic             i_wdata0,
  input  logic             i_wdata1,
  output logic [AW-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [AW-1:0]    o_waddr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_wen
);

  localparam int unsigned LW = $clog2(WIDTH);  // bit-in-word index width
  localparam int unsigned WW = 5 - LW;         // word-in-register index width
  localparam logic [WW-1:0] LastWord = {WW{1'b1}};
  localparam logic [LW-1:0] PosRd0 = LW'(WIDTH - 3);
  localparam logic [LW-1:0] PosRd1 = LW'(WIDTH - 2);
  localparam logic [LW-1:0] PosEnd = LW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRfetch, StRstream, StWstream} state_e;

  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  // Read-side state
  logic [WIDTH-1:0] rbuf0_q;
  logic [WIDTH-1:0] sr0_q, sr1_q;
  logic             rbuf_ld, sr_ld;
  logic [4:0]       rbit;
  logic [WW-1:0]    rword, rword_nxt;

  // Write-side state
  logic [WIDTH-1:0] acc0_q;
  logic [WIDTH-2:0] acc1_q;
  logic [WIDTH-1:0] wbuf1_q;
  logic [WW-1:0]    wword_q;
  logic             w0_go_q, w1_arm_q, w1_go_q;
  logic [4:0]       wbit;
  logic             wsample, wlast;

  assign rbit      = cnt_q[4:0];
  assign rword     = rbit[4:LW];
  assign rword_nxt = rword + 1'b1;

  // Write stream bit k is taken at cnt = k + 1
  assign wbit    = cnt_q[4:0] - 5'd1;
  assign wsample = (state_q == StWstream) && (cnt_q != 6'd0) && (cnt_q <= 6'd32);
  assign wlast   = wsample && (wbit[LW-1:0] == PosEnd);

  // State and cycle counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: requests only sampled in idle, write wins a collision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 6'd1;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_wreq) begin
          state_d = StWstream;
        end else if (i_rreq) begin
          state_d = StRfetch;
        end
      end
      StRfetch: begin
        if (cnt_q == 6'd2) begin
          state_d = StRstream;
          cnt_d   = '0;
        end
      end
      StRstream: begin
        if (cnt_q == 6'd31) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StWstream: begin
        if (cnt_q == 6'd34) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Read strobes, prefetch buffer capture and shift-register load points
  always_comb begin
    o_ren   = 1'b0;
    o_raddr = '0;
    rbuf_ld = 1'b0;
    sr_ld   = 1'b0;
    if (state_q == StRfetch) begin
      if (cnt_q == 6'd0) begin
        o_ren   = 1'b1;
        o_raddr = {i_rreg0, {WW{1'b0}}};
      end
      if (cnt_q == 6'd1) begin
        o_ren   = 1'b1;
        o_raddr = {i_rreg1, {WW{1'b0}}};
        rbuf_ld = 1'b1;
      end
      if (cnt_q == 6'd2) begin
        sr_ld = 1'b1;
      end
    end else if (state_q == StRstream && rword != LastWord) begin
      if (rbit[LW-1:0] == PosRd0) begin
        o_ren   = 1'b1;
        o_raddr = {i_rreg0, rword_nxt};
      end
      if (rbit[LW-1:0] == PosRd1) begin
        o_ren   = 1'b1;
        o_raddr = {i_rreg1, rword_nxt};
        rbuf_ld = 1'b1;
      end
      if (rbit[LW-1:0] == PosEnd) begin
        sr_ld = 1'b1;
      end
    end
  end

  // Read datapath; port 1 data arrives on the load edge so it goes straight to its shifter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rbuf0_q <= '0;
      sr0_q   <= '0;
      sr1_q   <= '0;
    end else begin
      if (rbuf_ld) begin
        rbuf0_q <= i_rdata;
      end
      if (sr_ld) begin
        sr0_q <= rbuf0_q;
        sr1_q <= i_rdata;
      end else if (state_q == StRstream) begin
        sr0_q <= sr0_q >> 1;
        sr1_q <= sr1_q >> 1;
      end
    end
  end

  assign o_rdata0 = sr0_q[0];
  assign o_rdata1 = sr1_q[0];
  assign o_ready  = ((state_q == StRfetch) && (cnt_q == 6'd2)) ||
                    ((state_q == StWstream) && (cnt_q == 6'd0));

  // Write datapath; port 1 word is held one extra cycle while port 0 is strobed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc0_q   <= '0;
      acc1_q   <= '0;
      wbuf1_q  <= '0;
      wword_q  <= '0;
      w0_go_q  <= 1'b0;
      w1_arm_q <= 1'b0;
      w1_go_q  <= 1'b0;
    end else begin
      w0_go_q  <= 1'b0;
      w1_arm_q <= 1'b0;
      w1_go_q  <= w1_arm_q;
      if (wsample) begin
        acc0_q <= {i_wdata0, acc0_q[WIDTH-1:1]};
        acc1_q <= {i_wdata1, acc1_q[WIDTH-2:1]};
      end
      if (wlast) begin
        w0_go_q  <= i_wen0;
        w1_arm_q <= i_wen1;
        wword_q  <= wbit[4:LW];
        wbuf1_q  <= {i_wdata1, acc1_q};
      end
    end
  end

  // RAM write port mux
  always_comb begin
    o_wen   = w0_go_q | w1_go_q;
    o_waddr = '0;
    o_wdata = '0;
    if (w0_go_q) begin
      o_waddr = {i_wreg0, wword_q};
      o_wdata = acc0_q;
    end else if (w1_go_q) begin
      o_waddr = {i_wreg1, wword_q};
      o_wdata = wbuf1_q;
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// Bench for serv_rf_ram_bridge: a WIDTH=8 and a WIDTH=4 bridge share the core-side stimulus,
// each backed by its own RAM model. A scoreboard checks o_ready timing, serial read data and
// the WIDTH=8 write strobes.
module tb_serv_rf_ram_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rreq = 0, wreq = 0;
  logic [5:0] rreg0 = 0, rreg1 = 0, wreg0 = 0, wreg1 = 0;
  logic       wen0 = 0, wen1 = 0, wdata0 = 0, wdata1 = 0;

  logic       ready8, rdata0_8, rdata1_8, ren8, wen8;
  logic [7:0] raddr8, waddr8, wdata8, rd8;
  logic       ready4, rdata0_4, rdata1_4, ren4, wen4;
  logic [8:0] raddr4, waddr4;
  logic [3:0] wdata4, rd4;

  logic [7:0] mem8[256];
  logic [3:0] mem4[512];

  serv_rf_ram_bridge #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_wreq(wreq), .o_ready(ready8),
    .i_rreg0(rreg0), .i_rreg1(rreg1), .o_rdata0(rdata0_8), .o_rdata1(rdata1_8),
    .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_raddr(raddr8), .o_ren(ren8), .i_rdata(rd8),
    .o_waddr(waddr8), .o_wdata(wdata8), .o_wen(wen8)
  );

  serv_rf_ram_bridge #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_wreq(wreq), .o_ready(ready4),
    .i_rreg0(rreg0), .i_rreg1(rreg1), .o_rdata0(rdata0_4), .o_rdata1(rdata1_4),
    .i_wreg0(wreg0), .i_wreg1(wreg1), .i_wen0(wen0), .i_wen1(wen1),
    .i_wdata0(wdata0), .i_wdata1(wdata1), .o_raddr(raddr4), .o_ren(ren4), .i_rdata(rd4),
    .o_waddr(waddr4), .o_wdata(wdata4), .o_wen(wen4)
  );

  // Synchronous RAM models: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ren8) rd8 <= mem8[raddr8];
    if (wen8) mem8[waddr8] <= wdata8;
    if (ren4) rd4 <= mem4[raddr4];
    if (wen4) mem4[waddr4] <= wdata4;
  end

  typedef struct {
    bit          wr;
    bit          col;
    int          poke;
    logic [5:0]  r0;
    logic [5:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          en0;
    bit          en1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  typedef struct {
    bit          wr;
    int          t;
    logic [31:0] e0;
    logic [31:0] e1;
  } rdy_t;

  typedef struct {
    int         t;
    logic [7:0] addr;
    logic [7:0] data;
  } stb_t;

  rdy_t rdy_q[$];
  stb_t stb_q[$];

  int checks = 0;
  int failures = 0;
  int rdy_viol = 0;
  int excl_viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic report_stray(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
  endtask

  task automatic check_zero(input string name);
    check({name, "_w8"}, {ready8, rdata0_8, rdata1_8, ren8, raddr8, wen8, waddr8, wdata8}, 0);
    check({name, "_w4"}, {ready4, rdata0_4, rdata1_4, ren4, raddr4, wen4, waddr4, wdata4}, 0);
  endtask

  // Drive one table entry starting in the current cycle; returns at T+36
  task automatic run_vec(input vec_t v);
    int t;
    stb_t s;
    t = cyc;
    rreg0 = v.r0;
    rreg1 = v.r1;
    wreg0 = v.r0;
    wreg1 = v.r1;
    wen0  = v.en0;
    wen1  = v.en1;
    rreq  = !v.wr || v.col;
    wreq  = v.wr;
    rdy_q.push_back('{wr: v.wr, t: t, e0: v.e0, e1: v.e1});
    if (v.wr) begin
      for (int n = 0; n < 4; n++) begin
        if (v.en0) begin
          s = '{t: t + 10 + 8 * n, addr: {v.r0, 2'(n)}, data: v.d0[8*n+:8]};
          stb_q.push_back(s);
        end
        if (v.en1) begin
          s = '{t: t + 11 + 8 * n, addr: {v.r1, 2'(n)}, data: v.d1[8*n+:8]};
          stb_q.push_back(s);
        end
      end
    end
    for (int i = 1; i <= 36; i++) begin
      @(posedge clk);
      #1;
      wreq = 1'b0;
      rreq = (v.poke != 0) && (i == v.poke);
      if (v.wr) begin
        wdata0 = (i >= 2 && i <= 33) ? v.d0[i-2] : 1'b0;
        wdata1 = (i >= 2 && i <= 33) ? v.d1[i-2] : 1'b0;
        if (i == 34) begin
          wen0 = 1'b0;
          wen1 = 1'b0;
        end
        if (i == 1) begin
          @(negedge clk);
          check("wr_no_ren_w8", ren8, 1'b0);
          check("wr_no_ren_w4", ren4, 1'b0);
        end
      end
    end
  endtask

  // Scoreboard monitor: pops expected events as the DUTs produce them
  logic [31:0] g80, g81, g40, g41;
  int   rd_k = 0;
  bit   rd_act = 0;
  rdy_t cur;
  stb_t got;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_act = 0;
      end else begin
        if (ready8 !== ready4) rdy_viol++;
        if ((ren8 === 1'b1 && wen8 === 1'b1) || (ren4 === 1'b1 && wen4 === 1'b1)) excl_viol++;
        if (wen8 === 1'b1) begin
          if (stb_q.size() == 0) begin
            report_stray("stray_wen");
          end else begin
            got = stb_q.pop_front();
            check("wen_time", cyc, got.t);
            check("wen_addr", waddr8, got.addr);
            check("wen_data", wdata8, got.data);
          end
        end
        if (rd_act) begin
          g80[rd_k] = rdata0_8;
          g81[rd_k] = rdata1_8;
          g40[rd_k] = rdata0_4;
          g41[rd_k] = rdata1_4;
          rd_k++;
          if (rd_k == 32) begin
            rd_act = 0;
            check("rd0_w8", g80, cur.e0);
            check("rd1_w8", g81, cur.e1);
            check("rd0_w4", g40, cur.e0);
            check("rd1_w4", g41, cur.e1);
          end
        end
        if (ready8 === 1'b1) begin
          if (rdy_q.size() == 0) begin
            report_stray("stray_ready");
          end else begin
            cur = rdy_q.pop_front();
            check("ready_time", cyc, cur.t + (cur.wr ? 1 : 3));
            if (!cur.wr) begin
              rd_act = 1;
              rd_k   = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[12];
  vec_t rv;
  logic [31:0] rst_data;
  int t0;

  initial begin
    tbl[0]  = '{wr: 1, col: 0, poke: 0, r0: 5, r1: 9, d0: 32'hDEADBEEF, d1: 32'hFFFFFFFF,
                en0: 1, en1: 0, e0: 0, e1: 0};
    tbl[1]  = '{wr: 0, col: 0, poke: 0, r0: 5, r1: 0, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'hDEADBEEF, e1: 32'h0};
    tbl[2]  = '{wr: 1, col: 0, poke: 0, r0: 3, r1: 33, d0: 32'h12345678, d1: 32'hA5A5A5A5,
                en0: 1, en1: 1, e0: 0, e1: 0};
    tbl[3]  = '{wr: 0, col: 0, poke: 0, r0: 3, r1: 33, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'h12345678, e1: 32'hA5A5A5A5};
    tbl[4]  = '{wr: 1, col: 0, poke: 0, r0: 1, r1: 2, d0: 32'hFFFFFFFF, d1: 32'h00000001,
                en0: 1, en1: 1, e0: 0, e1: 0};
    tbl[5]  = '{wr: 0, col: 0, poke: 0, r0: 1, r1: 2, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'hFFFFFFFF, e1: 32'h00000001};
    tbl[6]  = '{wr: 0, col: 0, poke: 15, r0: 2, r1: 1, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'h00000001, e1: 32'hFFFFFFFF};
    tbl[7]  = '{wr: 1, col: 1, poke: 0, r0: 10, r1: 11, d0: 32'hCAFEF00D, d1: 32'h0,
                en0: 1, en1: 0, e0: 0, e1: 0};
    tbl[8]  = '{wr: 1, col: 0, poke: 20, r0: 5, r1: 6, d0: 32'h11111111, d1: 32'h0BADF00D,
                en0: 0, en1: 1, e0: 0, e1: 0};
    tbl[9]  = '{wr: 0, col: 0, poke: 0, r0: 5, r1: 6, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'hDEADBEEF, e1: 32'h0BADF00D};
    tbl[10] = '{wr: 0, col: 0, poke: 0, r0: 10, r1: 9, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'hCAFEF00D, e1: 32'h0};
    tbl[11] = '{wr: 0, col: 0, poke: 0, r0: 33, r1: 3, d0: 0, d1: 0,
                en0: 0, en1: 0, e0: 32'hA5A5A5A5, e1: 32'h12345678};

    for (int i = 0; i < 256; i++) mem8[i] = '0;
    for (int i = 0; i < 512; i++) mem4[i] = '0;
    rd8 = '0;
    rd4 = '0;

    @(negedge clk);
    check_zero("rst_init");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Reset while bit 12 of a write to x7 is on the bus
    rst_data = 32'h77665544;
    t0 = cyc;
    wreq  = 1'b1;
    wreg0 = 6'd7;
    wreg1 = 6'd8;
    wen0  = 1'b1;
    wen1  = 1'b0;
    rdy_q.push_back('{wr: 1, t: t0, e0: 0, e1: 0});
    stb_q.push_back('{t: t0 + 10, addr: {6'd7, 2'd0}, data: 8'h44});
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      wreq = 1'b0;
      wdata0 = (i >= 2) ? rst_data[i-2] : 1'b0;
    end
    rst_n  = 1'b0;
    wen0   = 1'b0;
    wdata0 = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_x7_w8_word0", mem8[{6'd7, 2'd0}], 8'h44);
    check("rst_x7_w8_word1", mem8[{6'd7, 2'd1}], 8'h00);
    check("rst_x7_w4_word1", mem4[{6'd7, 3'd1}], 4'h4);
    check("rst_x7_w4_word2", mem4[{6'd7, 3'd2}], 4'h0);
    @(posedge clk);
    #1;
    rv = '{wr: 0, col: 0, poke: 0, r0: 7, r1: 5, d0: 0, d1: 0,
           en0: 0, en1: 0, e0: 32'h00000044, e1: 32'hDEADBEEF};
    run_vec(rv);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ready_queue_empty", rdy_q.size(), 0);
    check("wen_queue_empty", stb_q.size(), 0);
    check("ready_w8_w4_agree", rdy_viol, 0);
    check("ren_wen_exclusive", excl_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
